reg_ctrl_unit: RTL and testbench

- Sequencer for the two-register (x/y) register file: decodes one 16-bit instruction at a time and drives its write-select (rw) and one-hot load strobes (lse/ldm/lacc).
- Handshakes with the ALU (start/done) and data memory (rd/wr/ack); supplies the sign-extended immediate.
- Sits between the instruction source and the register file / ALU / memory port.

---
 rtl/reg_ctrl_unit.sv | 188 ++++++++++++++++++
 tb/tb_reg_ctrl_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_ctrl_unit.sv
// reg_ctrl_unit: x/y register-file sequencer; decodes one instruction, runs ALU/memory handshakes, pulses one load strobe.
// Latency accept->strobe: MOVI 2, LDR 2+ack wait, ALU 3+done wait; WAIT states abort after TIMEOUT cycles.
// Backpressure: instr_ready only in IDLE; define REG_CTRL_PERF_CNT_EN to add the retired_cnt output.
module reg_ctrl_unit #(
    parameter int TIMEOUT = 15,
    parameter int IMM_W   = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic        rw,
    output logic        lse,
    output logic        ldm,
    output logic        lacc,
    output logic [15:0] se_out,
    output logic [3:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic        mem_ack,
    output logic        busy,
    output logic        halted,
    output logic [1:0]  err,
    input  logic        err_clr
`ifdef REG_CTRL_PERF_CNT_EN
    ,
    output logic [15:0] retired_cnt
`endif
);

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_LDR  = 6'h01;
    localparam logic [5:0] OP_STR  = 6'h02;
    localparam logic [5:0] OP_MOVI = 6'h03;
    localparam logic [5:0] OP_HLT  = 6'h3F;
    localparam logic [7:0] TLAST   = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, DECODE, EXEC_ALU, WAIT_ALU, WAIT_MEM, WRITEBACK, HALT
    } state_t;

    state_t     state;
    logic [5:0] op;
    logic [7:0] tcnt;
    logic [1:0] err_base;
    logic       is_alu;

    // A new error bit set in the same cycle as err_clr survives the clear.
    assign err_base = err_clr ? 2'b00 : err;
    assign is_alu   = (op >= 6'h04) && (op <= 6'h0B);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op          <= '0;
            tcnt        <= '0;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            halted      <= 1'b0;
            rw          <= 1'b0;
            lse         <= 1'b0;
            ldm         <= 1'b0;
            lacc        <= 1'b0;
            se_out      <= '0;
            alu_op      <= '0;
            alu_start   <= 1'b0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            err         <= '0;
        end else begin
            lse       <= 1'b0;
            ldm       <= 1'b0;
            lacc      <= 1'b0;
            alu_start <= 1'b0;
            err       <= err_base;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        state       <= DECODE;
                        instr_ready <= 1'b0;
                        busy        <= 1'b1;
                        op          <= instr[15:10];
                        rw          <= instr[9];
                        alu_op      <= instr[13:10];
                        se_out      <= {{(16-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
                    end
                end
                DECODE: begin
                    tcnt <= '0;
                    if (op == OP_MOVI) begin
                        state <= WRITEBACK;
                        lse   <= 1'b1;
                    end else if (is_alu) begin
                        state     <= EXEC_ALU;
                        alu_start <= 1'b1;
                    end else if (op == OP_LDR) begin
                        state  <= WAIT_MEM;
                        mem_rd <= 1'b1;
                    end else if (op == OP_STR) begin
                        state  <= WAIT_MEM;
                        mem_wr <= 1'b1;
                    end else if (op == OP_HLT) begin
                        state  <= HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        if (op != OP_NOP)
                            err <= err_base | 2'b01;
                        state       <= IDLE;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                EXEC_ALU: begin
                    state <= WAIT_ALU;
                    tcnt  <= '0;
                end
                WAIT_ALU: begin
                    if (alu_done) begin
                        state <= WRITEBACK;
                        lacc  <= 1'b1;
                    end else if (tcnt == TLAST) begin
                        err         <= err_base | 2'b10;
                        state       <= IDLE;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                WAIT_MEM: begin
                    // An ack on the expiry cycle still completes the access.
                    if (mem_ack) begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        if (op == OP_LDR) begin
                            state <= WRITEBACK;
                            ldm   <= 1'b1;
                        end else begin
                            state       <= IDLE;
                            instr_ready <= 1'b1;
                            busy        <= 1'b0;
                        end
                    end else if (tcnt == TLAST) begin
                        mem_rd      <= 1'b0;
                        mem_wr      <= 1'b0;
                        err         <= err_base | 2'b10;
                        state       <= IDLE;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                WRITEBACK: begin
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                end
                HALT: state <= HALT;
                default: begin
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

`ifdef REG_CTRL_PERF_CNT_EN
    logic retire;

    assign retire = (state == WRITEBACK)
                 || (state == DECODE && op == OP_NOP)
                 || (state == WAIT_MEM && mem_ack && op == OP_STR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retired_cnt <= '0;
        else if (retire)
            retired_cnt <= retired_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_reg_ctrl_unit.sv
// Testbench for reg_ctrl_unit: instruction vector table with a strobe scoreboard, plus reset/error/halt sequences.
`timescale 1ns/1ps
module tb_reg_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        alu_done = 1'b0;
    logic        mem_ack = 1'b0;
    logic        err_clr = 1'b0;
    logic        instr_ready, rw, lse, ldm, lacc, alu_start, mem_rd, mem_wr, busy, halted;
    logic [15:0] se_out;
    logic [3:0]  alu_op;
    logic [1:0]  err;
`ifdef REG_CTRL_PERF_CNT_EN
    logic [15:0] retired_cnt;
    logic [15:0] exp_ret = '0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_ctrl_unit #(.TIMEOUT(15), .IMM_W(9)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rw(rw), .lse(lse), .ldm(ldm), .lacc(lacc), .se_out(se_out),
        .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ack(mem_ack),
        .busy(busy), .halted(halted), .err(err), .err_clr(err_clr)
`ifdef REG_CTRL_PERF_CNT_EN
        , .retired_cnt(retired_cnt)
`endif
    );

    typedef struct {
        logic [15:0] instr;
        int          dly;    // response on the dly-th wait/request cycle, 0 = never
        bit          early;  // also pulse alu_done during EXEC_ALU
        logic [2:0]  strb;   // {lacc, ldm, lse}
        int          lat;    // accept cycle to strobe cycle
        int          fin;    // cycle where instr_ready/halted returns
        logic [1:0]  err;
        int          rd;
        int          wr;
        int          alu;
        bit          halt;
        bit          ret;
    } vec_t;

    typedef struct {
        logic [2:0]  strb;
        logic        rw;
        logic [15:0] se;
        int          lat;
    } sb_t;

    vec_t vecs[15];
    sb_t  sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] sext9(input logic [15:0] i);
        logic [8:0] imm;
        imm = i[8:0];
        return {{7{imm[8]}}, imm};
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int    cyc, rdc, wrc, starts, waitc;
        bit    in_alu;
        sb_t   e;
        string tag;
        tag = $sformatf("v%0d", idx);
        check({tag, "_rdy_idle"}, instr_ready, 1);
        instr = v.instr;
        instr_valid = 1'b1;
        if (v.strb != 3'b000) begin
            e.strb = v.strb; e.rw = v.instr[9]; e.se = sext9(v.instr); e.lat = v.lat;
            sb.push_back(e);
        end
        tick;
        instr_valid = 1'b0;
        instr = 16'($urandom);
        cyc = 1; rdc = 0; wrc = 0; starts = 0; waitc = 0; in_alu = 1'b0;
        check({tag, "_se_decode"}, se_out, sext9(v.instr));
        check({tag, "_decode_rdy_busy"}, {instr_ready, busy}, 2'b01);
        while (!instr_ready && !halted && cyc < 60) begin
            alu_done = 1'b0;
            mem_ack  = 1'b0;
            if (lse | ldm | lacc) begin
                if (sb.size() == 0) begin
                    check({tag, "_unexpected_strobe"}, {lacc, ldm, lse}, 0);
                end else begin
                    e = sb.pop_front();
                    check({tag, "_strobe"}, {lacc, ldm, lse}, e.strb);
                    check({tag, "_strobe_rw"}, rw, e.rw);
                    check({tag, "_strobe_se"}, se_out, e.se);
                    check({tag, "_strobe_lat"}, cyc, e.lat);
                end
            end
            if (alu_start) begin
                starts++;
                check({tag, "_alu_op"}, alu_op, v.instr[13:10]);
                in_alu = 1'b1;
                waitc = 0;
                if (v.early) alu_done = 1'b1;
            end else if (in_alu) begin
                waitc++;
                if (waitc == v.dly) alu_done = 1'b1;
            end
            if (mem_rd) rdc++;
            if (mem_wr) wrc++;
            if ((mem_rd || mem_wr) && (rdc + wrc) == v.dly) mem_ack = 1'b1;
            tick;
            cyc++;
        end
        alu_done = 1'b0;
        mem_ack  = 1'b0;
        check({tag, "_end_cycle"}, cyc, v.fin);
        check({tag, "_err"}, err, v.err);
        check({tag, "_rd_cycles"}, rdc, v.rd);
        check({tag, "_wr_cycles"}, wrc, v.wr);
        check({tag, "_alu_starts"}, starts, v.alu);
        check({tag, "_halted"}, halted, v.halt);
        check({tag, "_req_dropped"}, {mem_rd, mem_wr}, 0);
        check({tag, "_sb_drained"}, sb.size(), 0);
        sb.delete();
`ifdef REG_CTRL_PERF_CNT_EN
        if (v.ret) exp_ret = exp_ret + 16'd1;
        check({tag, "_retired"}, retired_cnt, exp_ret);
`endif
        if (v.err != 2'b00) begin
            err_clr = 1'b1;
            tick;
            err_clr = 1'b0;
            check({tag, "_err_clr"}, err, 0);
        end
    endtask

    initial begin
        int n;
        bit seen, bad;
        //            instr     dly e  strb    lat fin err   rd  wr alu hlt ret
        vecs[0]  = '{16'h0FFF,  0, 0, 3'b001,  2,  3, 2'b00,  0, 0, 0, 0, 1}; // MOVI y, -1
        vecs[1]  = '{16'h0C05,  0, 0, 3'b001,  2,  3, 2'b00,  0, 0, 0, 0, 1}; // MOVI x, +5
        vecs[2]  = '{16'h0F00,  0, 0, 3'b001,  2,  3, 2'b00,  0, 0, 0, 0, 1}; // MOVI y, -256
        vecs[3]  = '{16'h1000,  4, 0, 3'b100,  7,  8, 2'b00,  0, 0, 1, 0, 1}; // ADD x
        vecs[4]  = '{16'h2E00,  3, 1, 3'b100,  6,  7, 2'b00,  0, 0, 1, 0, 1}; // op 0x0B, early done ignored
        vecs[5]  = '{16'h1400,  0, 0, 3'b000,  0, 18, 2'b10,  0, 0, 1, 0, 0}; // ALU timeout
        vecs[6]  = '{16'h1A00, 15, 0, 3'b100, 18, 19, 2'b00,  0, 0, 1, 0, 1}; // done on expiry cycle
        vecs[7]  = '{16'h0400,  0, 0, 3'b000,  0, 17, 2'b10, 15, 0, 0, 0, 0}; // LDR timeout
        vecs[8]  = '{16'h0400, 15, 0, 3'b010, 17, 18, 2'b00, 15, 0, 0, 0, 1}; // ack on expiry cycle
        vecs[9]  = '{16'h0600,  1, 0, 3'b010,  3,  4, 2'b00,  1, 0, 0, 0, 1}; // LDR y, fast ack
        vecs[10] = '{16'h0800,  2, 0, 3'b000,  0,  4, 2'b00,  0, 2, 0, 0, 1}; // STR
        vecs[11] = '{16'h0000,  0, 0, 3'b000,  0,  2, 2'b00,  0, 0, 0, 0, 1}; // NOP
        vecs[12] = '{16'h4000,  0, 0, 3'b000,  0,  2, 2'b01,  0, 0, 0, 0, 0}; // illegal 0x10
        vecs[13] = '{16'h3000,  0, 0, 3'b000,  0,  2, 2'b01,  0, 0, 0, 0, 0}; // illegal 0x0C
        vecs[14] = '{16'hFC00,  0, 0, 3'b000,  0,  2, 2'b00,  0, 0, 0, 1, 0}; // HLT

        repeat (3) tick;
        check("reset_outputs", {rw, lse, ldm, lacc, se_out, alu_op, alu_start, mem_rd, mem_wr, busy, halted, err}, 0);
        check("reset_ready", instr_ready, 1);
        rst = 1'b0;
        tick;

        // Reset while waiting on the ALU must abort without a writeback.
        instr = 16'h1000;
        instr_valid = 1'b1;
        tick;
        instr_valid = 1'b0;
        n = 0;
        while (!alu_start && n < 10) begin
            tick;
            n++;
        end
        check("rstmid_start_seen", alu_start, 1);
        tick;
        tick;
        #2 rst = 1'b1;
        #1;
        check("rstmid_outputs", {lse, ldm, lacc, alu_start, mem_rd, mem_wr, busy, halted, err}, 0);
        check("rstmid_ready", instr_ready, 1);
        tick;
        rst = 1'b0;
        alu_done = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (lacc || !instr_ready) seen = 1'b1;
            tick;
            alu_done = 1'b0;
        end
        check("rstmid_no_lacc", seen, 0);
`ifdef REG_CTRL_PERF_CNT_EN
        exp_ret = '0;
`endif

        // Error set wins over a simultaneous clear.
        err_clr = 1'b1;
        instr = 16'h4000;
        instr_valid = 1'b1;
        tick;
        instr_valid = 1'b0;
        tick;
        check("errprio_set_wins", err, 2'b01);
        tick;
        check("errprio_clear", err, 2'b00);
        err_clr = 1'b0;

        for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

        // HALT is terminal: offered instructions are refused until reset.
        instr = 16'h0FFF;
        instr_valid = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!halted || instr_ready || busy || lse) bad = 1'b1;
            tick;
        end
        instr_valid = 1'b0;
        check("halt_held", bad, 0);
        #2 rst = 1'b1;
        tick;
        rst = 1'b0;
        check("halt_reset", {halted, instr_ready}, 2'b01);
`ifdef REG_CTRL_PERF_CNT_EN
        exp_ret = '0;
`endif
        run_vec(vecs[0], 100);

`ifdef REG_CTRL_PERF_CNT_EN
        force dut.retired_cnt = 16'hFFFF;
        #1;
        release dut.retired_cnt;
        exp_ret = 16'hFFFF;
        run_vec(vecs[11], 101);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
